// File: rtl/hd44780_responder.sv
// hd44780_responder: display-side model of the HD44780 LCD bus.
// Holds the 80-cell DDRAM, AC, BF and display state; answers status/data reads.
module hd44780_responder #(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       wr_strobe,
    output logic [7:0] wr_char,
    output logic       busy_violation,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);

    localparam int unsigned MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] T_BUSY  = TW'(BUSY_CYCLES);
    localparam logic [TW-1:0] T_CLEAR = TW'(CLEAR_CYCLES);
    localparam int NCELL = 80;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // Returns {valid, cell index}; two-line mode folds 0x40-0x67 onto cells 40-79.
    function automatic logic [7:0] map_addr(input logic [6:0] a, input logic n);
        logic [7:0] r;
        r = 8'h00;
        if (n) begin
            if (a <= 7'h27) r = {1'b1, a};
            else if (a >= 7'h40 && a <= 7'h67) r = {1'b1, a - 7'd24};
        end else if (a <= 7'h4f) begin
            r = {1'b1, a};
        end
        return r;
    endfunction

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc,
                                             input logic n);
        logic [6:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (n) begin
            if (inc && a == 7'h27) r = 7'h40;
            else if (inc && a == 7'h67) r = 7'h00;
            else if (!inc && a == 7'h00) r = 7'h67;
            else if (!inc && a == 7'h40) r = 7'h27;
        end else begin
            if (inc && a == 7'h4f) r = 7'h00;
            else if (!inc && a == 7'h00) r = 7'h4f;
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [6:0]      clr_idx_q, clr_idx_d;
    logic [7:0]      mem_q [NCELL];
    logic [7:0]      mem_d [NCELL];
    logic [6:0]      ac_q, ac_d;
    logic            id_q, id_d;
    logic            s_q, s_d;
    logic            d_q, d_d;
    logic            c_q, c_d;
    logic            b_q, b_d;
    logic            n_q, n_d;
    logic [10:0]     sync1_q, sync1_d;
    logic [10:0]     sync2_q, sync2_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [7:0]      wr_char_q, wr_char_d;
    logic            viol_q, viol_d;

    logic            e_s, rs_s, rw_s, fall, busy_int;
    logic [7:0]      din_s, ac_map, dbg_map, rd_data;

    assign e_s   = sync2_q[10];
    assign rs_s  = sync2_q[9];
    assign rw_s  = sync2_q[8];
    assign din_s = sync2_q[7:0];
    assign fall  = sync2_q[10] & ~sync1_q[10];

    assign busy_int = (timer_q != '0) || (state_q == S_CLEAR);
    assign ac_map   = map_addr(ac_q, n_q);
    assign dbg_map  = map_addr(dbg_addr, n_q);

    always_comb begin
        rd_data = {busy_int, ac_q};
        if (rs_s) rd_data = ac_map[7] ? mem_q[ac_map[6:0]] : 8'h00;
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        clr_idx_d   = clr_idx_q;
        mem_d       = mem_q;
        ac_d        = ac_q;
        id_d        = id_q;
        s_d         = s_q;
        d_d         = d_q;
        c_d         = c_q;
        b_d         = b_q;
        n_d         = n_q;
        sync1_d     = {E, RS, RW, data_in};
        sync2_d     = sync1_q;
        data_out_d  = data_oe ? rd_data : data_out_q;
        wr_strobe_d = 1'b0;
        wr_char_d   = wr_char_q;
        viol_d      = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                mem_d[clr_idx_q] = 8'h20;
                if (clr_idx_q == 7'(NCELL - 1)) begin
                    state_d   = S_IDLE;
                    clr_idx_d = 7'd0;
                    ac_d      = 7'd0;
                    id_d      = 1'b1;
                end else begin
                    clr_idx_d = clr_idx_q + 7'd1;
                end
            end
            S_IDLE: begin
                if (fall && rw_s) begin
                    if (rs_s) ac_d = step_addr(ac_q, id_q, n_q);
                end else if (fall && busy_int) begin
                    viol_d = 1'b1;
                end else if (fall && rs_s) begin
                    timer_d = T_BUSY;
                    ac_d    = step_addr(ac_q, id_q, n_q);
                    if (ac_map[7]) begin
                        mem_d[ac_map[6:0]] = din_s;
                        wr_strobe_d        = 1'b1;
                        wr_char_d          = din_s;
                    end
                end else if (fall) begin
                    timer_d = T_BUSY;
                    if (din_s[7]) begin
                        ac_d = din_s[6:0];
                    end else if (din_s[6]) begin
                        // CGRAM address: no character generator modelled
                    end else if (din_s[5]) begin
                        n_d = din_s[3];
                    end else if (din_s[4]) begin
                        if (!din_s[3]) ac_d = step_addr(ac_q, din_s[2], n_q);
                    end else if (din_s[3]) begin
                        {d_d, c_d, b_d} = din_s[2:0];
                    end else if (din_s[2]) begin
                        id_d = din_s[1];
                        s_d  = din_s[0];
                    end else if (din_s[1]) begin
                        ac_d    = 7'd0;
                        timer_d = T_CLEAR;
                    end else if (din_s[0]) begin
                        state_d   = S_CLEAR;
                        clr_idx_d = 7'd0;
                        timer_d   = T_CLEAR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            clr_idx_q   <= 7'd0;
            for (int i = 0; i < NCELL; i++) mem_q[i] <= 8'h20;
            ac_q        <= 7'd0;
            id_q        <= 1'b1;
            s_q         <= 1'b0;
            d_q         <= 1'b0;
            c_q         <= 1'b0;
            b_q         <= 1'b0;
            n_q         <= 1'b1;
            sync1_q     <= '0;
            sync2_q     <= '0;
            data_out_q  <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_char_q   <= 8'h00;
            viol_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            clr_idx_q   <= clr_idx_d;
            mem_q       <= mem_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            s_q         <= s_d;
            d_q         <= d_d;
            c_q         <= c_d;
            b_q         <= b_d;
            n_q         <= n_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            data_out_q  <= data_out_d;
            wr_strobe_q <= wr_strobe_d;
            wr_char_q   <= wr_char_d;
            viol_q      <= viol_d;
        end
    end

    assign data_oe        = e_s & rw_s;
    assign data_out       = data_out_q;
    assign busy           = busy_int;
    assign ac             = ac_q;
    assign disp_on        = d_q;
    assign cursor_on      = c_q;
    assign blink_on       = b_q;
    assign two_line       = n_q;
    assign wr_strobe      = wr_strobe_q;
    assign wr_char        = wr_char_q;
    assign busy_violation = viol_q;
    assign dbg_char       = dbg_map[7] ? mem_q[dbg_map[6:0]] : 8'h00;

endmodule

// File: tb/tb_hd44780_responder.sv
// tb_hd44780_responder: table-driven bus transactions with a write-strobe scoreboard.
// Short BF timings keep the run small.
module tb_hd44780_responder;

    localparam int B = 20;
    localparam int C = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       E = 1'b0;
    logic       RS = 1'b0;
    logic       RW = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, two_line;
    logic       wr_strobe;
    logic [7:0] wr_char;
    logic       busy_violation;
    logic [6:0] dbg_addr = 7'h00;
    logic [7:0] dbg_char;

    int n_cmp = 0;
    int n_bad = 0;
    int viol_cnt = 0;
    logic [7:0] exp_q [$];

    hd44780_responder #(.BUSY_CYCLES(B), .CLEAR_CYCLES(C)) dut (
        .clk(clk), .reset(reset), .E(E), .RS(RS), .RW(RW),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .busy(busy), .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .two_line(two_line), .wr_strobe(wr_strobe),
        .wr_char(wr_char), .busy_violation(busy_violation),
        .dbg_addr(dbg_addr), .dbg_char(dbg_char)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] ac;
        logic [3:0] ndcb;
        logic [6:0] dbg_a;
        logic [7:0] dbg_c;
        logic       strobe;
        int         bsy;
    } vec_t;

    vec_t vt [23];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy_violation === 1'b1) viol_cnt++;
        if (wr_strobe === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got wr_char %0h expected no strobe", wr_char);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (wr_char !== e) begin
                    n_bad++;
                    $display("FAIL sb_wr_char: got %0h expected %0h", wr_char, e);
                end
            end
        end
    end

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = 1'b0; data_in = d; E = 1'b1;
        repeat (4) @(negedge clk);
        E = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        int t;
        t = 0;
        cyc = 0;
        while (busy !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        while (busy === 1'b1 && cyc < 1000) begin cyc++; @(negedge clk); end
        if (t >= 10 || cyc >= 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got t=%0d cyc=%0d expected BF pulse", t, cyc);
        end
    endtask

    task automatic check_dbg(input string nm, input logic [6:0] a, input logic [7:0] c);
        dbg_addr = a;
        #1;
        check(nm, dbg_char, c);
    endtask

    initial begin
        int cnt;
        int v0;
        int bad_cells;

        vt[0]  = '{1'b0, 8'h38, 7'h00, 4'b1000, 7'h00, 8'h20, 1'b0, B};
        vt[1]  = '{1'b0, 8'h0C, 7'h00, 4'b1100, 7'h00, 8'h20, 1'b0, B};
        vt[2]  = '{1'b0, 8'h06, 7'h00, 4'b1100, 7'h00, 8'h20, 1'b0, B};
        vt[3]  = '{1'b1, 8'h83, 7'h01, 4'b1100, 7'h00, 8'h83, 1'b1, B};
        vt[4]  = '{1'b0, 8'hA7, 7'h27, 4'b1100, 7'h00, 8'h83, 1'b0, B};
        vt[5]  = '{1'b1, 8'h41, 7'h40, 4'b1100, 7'h27, 8'h41, 1'b1, B};
        vt[6]  = '{1'b1, 8'h42, 7'h41, 4'b1100, 7'h40, 8'h42, 1'b1, B};
        vt[7]  = '{1'b0, 8'h04, 7'h41, 4'b1100, 7'h40, 8'h42, 1'b0, B};
        vt[8]  = '{1'b0, 8'hC0, 7'h40, 4'b1100, 7'h40, 8'h42, 1'b0, B};
        vt[9]  = '{1'b1, 8'h55, 7'h27, 4'b1100, 7'h40, 8'h55, 1'b1, B};
        vt[10] = '{1'b1, 8'h56, 7'h26, 4'b1100, 7'h27, 8'h56, 1'b1, B};
        vt[11] = '{1'b0, 8'h06, 7'h26, 4'b1100, 7'h27, 8'h56, 1'b0, B};
        vt[12] = '{1'b0, 8'h10, 7'h25, 4'b1100, 7'h28, 8'h00, 1'b0, B};
        vt[13] = '{1'b0, 8'h14, 7'h26, 4'b1100, 7'h67, 8'h20, 1'b0, B};
        vt[14] = '{1'b0, 8'h18, 7'h26, 4'b1100, 7'h00, 8'h83, 1'b0, B};
        vt[15] = '{1'b0, 8'h30, 7'h26, 4'b0100, 7'h40, 8'h20, 1'b0, B};
        vt[16] = '{1'b0, 8'hCF, 7'h4F, 4'b0100, 7'h50, 8'h00, 1'b0, B};
        vt[17] = '{1'b1, 8'h61, 7'h00, 4'b0100, 7'h4F, 8'h61, 1'b1, B};
        vt[18] = '{1'b0, 8'h38, 7'h00, 4'b1100, 7'h67, 8'h61, 1'b0, B};
        vt[19] = '{1'b0, 8'hB0, 7'h30, 4'b1100, 7'h41, 8'h20, 1'b0, B};
        vt[20] = '{1'b1, 8'h77, 7'h31, 4'b1100, 7'h30, 8'h00, 1'b0, B};
        vt[21] = '{1'b0, 8'h0F, 7'h31, 4'b1111, 7'h27, 8'h56, 1'b0, B};
        vt[22] = '{1'b0, 8'h02, 7'h00, 4'b1111, 7'h00, 8'h83, 1'b0, C};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_ac", ac, 7'h00);
        check("rst_ndcb", {two_line, disp_on, cursor_on, blink_on}, 4'b1000);
        check("rst_oe_out", {data_oe, data_out}, 9'h000);
        check("rst_strobes", {wr_strobe, busy_violation}, 2'b00);
        check_dbg("rst_dbg", 7'h00, 8'h20);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            if (vt[i].strobe) exp_q.push_back(vt[i].d);
            bus_write(vt[i].rs, vt[i].d);
            wait_idle(cnt);
            check($sformatf("v%0d_bf_len", i), cnt, vt[i].bsy);
            check($sformatf("v%0d_ac", i), ac, vt[i].ac);
            check($sformatf("v%0d_ndcb", i),
                  {two_line, disp_on, cursor_on, blink_on}, vt[i].ndcb);
            check_dbg($sformatf("v%0d_dbg", i), vt[i].dbg_a, vt[i].dbg_c);
            check($sformatf("v%0d_sb_left", i), exp_q.size(), 0);
        end

        bus_write(1'b0, 8'h90);
        wait_idle(cnt);
        exp_q.push_back(8'h99);
        bus_write(1'b1, 8'h99);
        repeat (2) @(negedge clk);
        v0 = viol_cnt;
        bus_write(1'b1, 8'hAA);
        wait_idle(cnt);
        check("viol_pulses", viol_cnt - v0, 1);
        check("viol_ac", ac, 7'h11);
        check_dbg("viol_dbg10", 7'h10, 8'h99);
        check_dbg("viol_dbg11", 7'h11, 8'h20);
        check("viol_sb_left", exp_q.size(), 0);

        bus_write(1'b0, 8'h04);
        wait_idle(cnt);
        bus_write(1'b0, 8'h01);
        wait_idle(cnt);
        check("clr_bf_len", cnt, C);
        check("clr_ac", ac, 7'h00);
        bad_cells = 0;
        for (int a = 0; a < 128; a++) begin
            if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
                dbg_addr = 7'(a);
                #1;
                if (dbg_char !== 8'h20) bad_cells++;
            end
        end
        check("clr_fill", bad_cells, 0);
        exp_q.push_back(8'h83);
        bus_write(1'b1, 8'h83);
        wait_idle(cnt);
        check("clr_id_inc", ac, 7'h01);
        bus_write(1'b0, 8'hE7);
        wait_idle(cnt);
        exp_q.push_back(8'h5A);
        bus_write(1'b1, 8'h5A);
        wait_idle(cnt);
        check("wrap67_ac", ac, 7'h00);

        bus_write(1'b0, 8'h01);
        repeat (30) @(negedge clk);
        check("clr2_busy_mid", busy, 1'b1);
        check_dbg("clr2_dbg_mid", 7'h67, 8'h5A);
        reset = 1'b1;
        #1;
        check("clr2_rst_busy", busy, 1'b0);
        check("clr2_rst_ac", ac, 7'h00);
        check("clr2_rst_ndcb", {two_line, disp_on, cursor_on, blink_on}, 4'b1000);
        check_dbg("clr2_rst_dbg", 7'h67, 8'h20);
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("clr2_no_resume", busy, 1'b0);

        exp_q.push_back(8'h83);
        bus_write(1'b1, 8'h83);
        wait_idle(cnt);
        bus_write(1'b0, 8'h80);
        @(negedge clk);
        RS = 1'b0; RW = 1'b1; E = 1'b1;
        repeat (4) @(negedge clk);
        check("rd_st_oe", data_oe, 1'b1);
        check("rd_st_bf", busy, 1'b1);
        check("rd_st_out", data_out, 8'h80);
        E = 1'b0;
        repeat (3) @(negedge clk);
        check("rd_st_oe_off", data_oe, 1'b0);
        check("rd_st_ac", ac, 7'h00);
        wait_idle(cnt);
        RS = 1'b1; RW = 1'b1; E = 1'b1;
        repeat (4) @(negedge clk);
        check("rd_dat_oe", data_oe, 1'b1);
        check("rd_dat_out", data_out, 8'h83);
        E = 1'b0;
        repeat (4) @(negedge clk);
        check("rd_dat_ac", ac, 7'h01);
        check("rd_dat_nobf", busy, 1'b0);
        check("rd_dat_oe_off", data_oe, 1'b0);
        check("end_sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
